// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared types and constants for the dot-matrix row scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      WAIT    = 3'd2,
      SHIFT   = 3'd3,
      LATCH   = 3'd4,
      DISPLAY = 3'd5
   } state_t;

   localparam int ROWS         = 8;
   localparam int BITS_PER_ROW = 8;

endpackage
`default_nettype wire

// File: rtl/shift_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : shift_phase_gen
// Description : DIV-cycle prescaler giving the column shift clock level and a
//               one-cycle pulse on the last high cycle of each bit.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_phase_gen #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sclk,
   output logic bit_done
);

   localparam int             CW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  c_last = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_high;

   // Count DIV cycles per half-bit; idle at phase 0, sclk low when disabled
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         r_cnt  <= '0;
         r_high <= 1'b0;
      end else if (r_cnt == c_last) begin
         r_cnt  <= '0;
         r_high <= ~r_high;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   assign sclk     = r_high;
   assign bit_done = en && r_high && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matrix_scan_ctrl
// Description : Row-scan sequencer for an 8x8 dot-matrix display: fetches a
//               row pattern, steps the pixel mux with a shift clock, latches
//               the column driver and lights the row for a fixed hold time.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_scan_ctrl
   import display_pkg::*;
#(
   parameter int DIV         = 2,
   parameter int HOLD_CYCLES = 1000,
   parameter int ROWS        = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   output logic            mem_rd,
   output logic [2:0]      mem_addr,
   input  logic [7:0]      mem_data,
   output logic [7:0]      dout,
   output logic [2:0]      sel,
   output logic            sclk,
   output logic            latch,
   output logic [ROWS-1:0] row_n,
   output logic            frame_done
);

   localparam int            HW          = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] c_hold_last = HW'(HOLD_CYCLES - 1);
   localparam logic [2:0]    c_last_bit  = 3'(BITS_PER_ROW - 1);
   localparam logic [2:0]    c_last_row  = 3'(ROWS - 1);

   state_t          r_state;
   state_t          w_next;
   logic [2:0]      r_row;
   logic [2:0]      r_sel;
   logic [7:0]      r_dout;
   logic [ROWS-1:0] r_row_n;
   logic [HW-1:0]   r_hold;
   logic            r_frame_done;
   logic            w_shift_en;
   logic            w_bit_done;
   logic            w_hold_last;
   logic            w_last_bit;

   assign w_shift_en  = (r_state == SHIFT);
   assign w_hold_last = (r_state == DISPLAY) && (r_hold == c_hold_last);
   assign w_last_bit  = (r_sel == c_last_bit);

   shift_phase_gen #(
      .DIV      (DIV)
   ) u_phase (
      .clk      (clk),
      .rst      (rst),
      .en       (w_shift_en),
      .sclk     (sclk),
      .bit_done (w_bit_done)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic and per-state strobes
   always_comb begin
      w_next   = r_state;
      mem_rd   = 1'b0;
      mem_addr = 3'd0;
      latch    = 1'b0;
      case (r_state)
         IDLE:    if (en) w_next = FETCH;
         FETCH: begin
            mem_rd   = 1'b1;
            mem_addr = r_row;
            w_next   = WAIT;
         end
         WAIT:    w_next = SHIFT;
         SHIFT:   if (w_bit_done && w_last_bit) w_next = LATCH;
         LATCH: begin
            latch  = 1'b1;
            w_next = DISPLAY;
         end
         DISPLAY: if (w_hold_last) w_next = en ? FETCH : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Row pointer, mux select, pattern hold, row drive and hold timer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row        <= 3'd0;
         r_sel        <= 3'd0;
         r_dout       <= 8'd0;
         r_row_n      <= '1;
         r_hold       <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_hold       <= '0;
         case (r_state)
            WAIT: begin
               r_dout <= mem_data;
               r_sel  <= 3'd0;
            end
            SHIFT: begin
               if (w_bit_done) begin
                  // Blank ahead of the latch so the new columns never show on the old row
                  if (w_last_bit) r_row_n <= '1;
                  else            r_sel   <= r_sel + 3'd1;
               end
            end
            LATCH: r_row_n <= ~(ROWS'(1) << r_row);
            DISPLAY: begin
               if (w_hold_last) begin
                  r_frame_done <= (r_row == c_last_row);
                  r_row        <= (r_row == c_last_row) ? 3'd0 : r_row + 3'd1;
                  if (!en) begin
                     // IDLE shows reset values, so clear the visible outputs on the way in
                     r_row_n <= '1;
                     r_sel   <= 3'd0;
                     r_dout  <= 8'd0;
                  end
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sel        = r_sel;
   assign dout       = r_dout;
   assign row_n      = r_row_n;
   assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_scan_ctrl
// Description : Self-checking bench for matrix_scan_ctrl. Two instances
//               (DIV=2/HOLD=4 and DIV=3/HOLD=1) run against a row-time model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rst;
   logic [1:0] en;
   logic [7:0] mem_data [2];
   logic [7:0] mem [2][8];

   logic       mem_rd_0, mem_rd_1, sclk_0, sclk_1, latch_0, latch_1, fd_0, fd_1;
   logic [2:0] addr_0, addr_1, sel_0, sel_1;
   logic [7:0] dout_0, dout_1, rown_0, rown_1;

   int n_err    = 0;
   int n_checks = 0;

   matrix_scan_ctrl #(.DIV(2), .HOLD_CYCLES(4), .ROWS(8)) dut0 (
      .clk(clk), .rst(rst[0]), .en(en[0]), .mem_rd(mem_rd_0), .mem_addr(addr_0),
      .mem_data(mem_data[0]), .dout(dout_0), .sel(sel_0), .sclk(sclk_0),
      .latch(latch_0), .row_n(rown_0), .frame_done(fd_0));

   matrix_scan_ctrl #(.DIV(3), .HOLD_CYCLES(1), .ROWS(8)) dut1 (
      .clk(clk), .rst(rst[1]), .en(en[1]), .mem_rd(mem_rd_1), .mem_addr(addr_1),
      .mem_data(mem_data[1]), .dout(dout_1), .sel(sel_1), .sclk(sclk_1),
      .latch(latch_1), .row_n(rown_1), .frame_done(fd_1));

   function automatic int divof(input int g);
      return (g == 0) ? 2 : 3;
   endfunction
   function automatic int holdof(input int g);
      return (g == 0) ? 4 : 1;
   endfunction

   task automatic check(input string name, input int g, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d at %0t: got %0h, expected %0h", name, g, $time, act, exp);
      end
   endtask

   // Model: position t inside the row period, current row, lit-row pattern
   bit m_valid = 1'b0;
   bit m_act [2];
   int m_t [2], m_row [2], m_rown [2], m_dout [2], m_cyc [2];
   bit m_fd [2];

   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         // frame memory: data one cycle after the read strobe
         if (g == 0 ? mem_rd_0 : mem_rd_1) mem_data[g] <= mem[g][g == 0 ? addr_0 : addr_1];
         if (rst[g]) begin
            m_valid  = 1'b1;
            m_act[g] = 1'b0; m_t[g] = 0; m_row[g] = 0; m_rown[g] = 255;
            m_dout[g] = 0; m_fd[g] = 1'b0; m_cyc[g] = 0;
         end else begin
            m_cyc[g]++;
            m_fd[g] = 1'b0;
            if (!m_act[g]) begin
               if (en[g]) begin m_act[g] = 1'b1; m_t[g] = 0; end
            end else begin
               if (m_t[g] == 1) m_dout[g] = int'(mem[g][m_row[g]]);
               if (m_t[g] == 1 + 16 * divof(g)) m_rown[g] = 255;
               if (m_t[g] == 2 + 16 * divof(g)) m_rown[g] = 255 & ~(1 << m_row[g]);
               if (m_t[g] == 2 + 16 * divof(g) + holdof(g)) begin
                  m_fd[g]  = (m_row[g] == 7);
                  m_row[g] = (m_row[g] + 1) % 8;
                  m_t[g]   = 0;
                  if (!en[g]) begin m_act[g] = 1'b0; m_rown[g] = 255; m_dout[g] = 0; end
               end else begin
                  m_t[g]++;
               end
            end
         end
      end
   end

   // Event trackers for the hand-computed timing pins
   int nrd [2], first_rd [2], nlat [2], nfd [2], last_fd [2], rises [2];
   bit prev_sclk [2];
   int resume_pin [2];
   bit resume_done [2];

   always @(negedge clk) begin
      if (m_valid) begin
         for (int g = 0; g < 2; g++) begin : b_cmp
            int d, ls, t, k, esel;
            bit act, sh, a_rd, a_sclk, a_lat, a_fd;
            int a_addr, a_sel, a_dout, a_rown;
            d      = divof(g);
            ls     = 2 + 16 * d;
            act    = m_act[g];
            t      = m_t[g];
            k      = t - 2;
            sh     = act && t >= 2 && t < ls;
            a_rd   = (g == 0) ? mem_rd_0 : mem_rd_1;
            a_sclk = (g == 0) ? sclk_0   : sclk_1;
            a_lat  = (g == 0) ? latch_0  : latch_1;
            a_fd   = (g == 0) ? fd_0     : fd_1;
            a_addr = int'((g == 0) ? addr_0 : addr_1);
            a_sel  = int'((g == 0) ? sel_0  : sel_1);
            a_dout = int'((g == 0) ? dout_0 : dout_1);
            a_rown = int'((g == 0) ? rown_0 : rown_1);

            check("mem_rd", g, int'(a_rd), int'(act && t == 0));
            check("latch", g, int'(a_lat), int'(act && t == ls));
            check("sclk", g, int'(a_sclk), int'(sh && (k % (2 * d)) >= d));
            check("row_n", g, a_rown, m_rown[g]);
            check("frame_done", g, int'(a_fd), int'(m_fd[g]));
            if (act && t == 0) check("mem_addr", g, a_addr, m_row[g]);
            if (!act) begin
               check("idle_sel", g, a_sel, 0);
               check("idle_dout", g, a_dout, 0);
               check("idle_addr", g, a_addr, 0);
            end else if (t >= 2) begin
               esel = sh ? k / (2 * d) : 7;
               check("sel", g, a_sel, esel);
               check("dout", g, a_dout, m_dout[g]);
            end

            if (m_cyc[g] == 0) begin
               nrd[g] = 0; nlat[g] = 0; nfd[g] = 0; rises[g] = 0; prev_sclk[g] = 1'b0;
            end else begin
               if (a_rd) begin
                  nrd[g]++;
                  if (nrd[g] == 1) begin
                     check("first_fetch_cycle", g, m_cyc[g], 1);
                     check("first_fetch_addr", g, a_addr, 0);
                     first_rd[g] = m_cyc[g];
                  end
                  if (nrd[g] == 2) check("row_period", g, m_cyc[g] - first_rd[g], (g == 0) ? 39 : 52);
                  if (resume_pin[g] >= 0 && !resume_done[g]) begin
                     check("resume_addr", g, a_addr, resume_pin[g]);
                     resume_done[g] = 1'b1;
                  end
               end
               if (a_sclk && !prev_sclk[g]) rises[g]++;
               prev_sclk[g] = a_sclk;
               if (a_lat) begin
                  nlat[g]++;
                  if (nlat[g] == 1) check("first_latch_cycle", g, m_cyc[g], (g == 0) ? 35 : 51);
                  check("sclk_rises_per_row", g, rises[g], 8);
                  rises[g] = 0;
               end
               if (a_fd) begin
                  nfd[g]++;
                  if (nfd[g] == 1) begin
                     check("first_frame_done", g, m_cyc[g], (g == 0) ? 313 : 417);
                     last_fd[g] = m_cyc[g];
                  end
                  if (nfd[g] == 2) check("frame_period", g, m_cyc[g] - last_fd[g], (g == 0) ? 312 : 416);
               end
            end
         end
      end
   end

   // Stimulus
   int cyc_main = 0;

   task automatic tick();
      @(negedge clk);
      cyc_main++;
      if (cyc_main > 900) en[1] = (($urandom % 4) != 0);
   endtask

   task automatic wait_fetch(input logic [2:0] a);
      int n;
      n = 0;
      tick();
      while (!(mem_rd_0 && addr_0 == a)) begin
         tick();
         n++;
         if (n > 500) begin
            $display("FAIL wait_fetch timeout: got no fetch of row %0d, expected one within 500 cycles", a);
            $fatal(1, "timeout");
         end
      end
   endtask

   task automatic wait_latch();
      int n;
      n = 0;
      tick();
      while (!latch_0) begin
         tick();
         n++;
         if (n > 500) begin
            $display("FAIL wait_latch timeout: got no latch, expected one within 500 cycles");
            $fatal(1, "timeout");
         end
      end
   endtask

   initial begin
      rst = 2'b11;
      en  = 2'b00;
      resume_pin[0] = -1; resume_pin[1] = -1;
      resume_done[0] = 1'b0; resume_done[1] = 1'b0;
      mem_data[0] = 8'h00; mem_data[1] = 8'h00;
      mem[0][0] = 8'hA5;
      mem[0][1] = 8'h3C;
      for (int r = 2; r < 8; r++) mem[0][r] = 8'($urandom);
      for (int r = 0; r < 8; r++) mem[1][r] = 8'($urandom);

      repeat (3) tick();
      en = 2'b11;
      tick();
      rst = 2'b00;

      // Two full frames with enable held
      repeat (700) tick();

      // Drop enable in the middle of row 3 shifting
      wait_fetch(3'd3);
      repeat (6) tick();
      en[0] = 1'b0;
      repeat (60) tick();
      resume_pin[0] = 4;
      en[0] = 1'b1;

      // Reset while row 5 is lit
      wait_fetch(3'd5);
      wait_latch();
      tick();
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      repeat (700) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
